key_uart_sender: RTL and testbench
==================================

Name: key_uart_sender

Overview:
- Consumes the debounced key event pair (key_flag, key_state) from the key filter stage.
- Counts key presses and transmits each new press count as one 8N1 UART frame on uart_tx, so presses can be observed on a host terminal.
- Holds one pending press while a frame is in flight. Flags overrun when a newer press overwrites an unsent one.
- Sits between the key filter and the board TX pin.

Parameters:
- BAUD_DIV, 5208, clock cycles per UART bit (50 MHz / 9600); legal range 2..65535.
- CNT_W, 16, width of the internal baud counter; must hold BAUD_DIV-1.

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- key_flag  in  1  one-cycle event strobe from key filter
- key_state  in  1  debounced level qualifying key_flag: 0 = pressed, 1 = released
- uart_tx  out  1  serial line, idle high
- tx_busy  out  1  high while a frame (start..stop) is on the line
- tx_done  out  1  one-cycle pulse in the last cycle of a stop bit
- press_cnt  out  8  running press count
- overrun  out  1  sticky; set when a pending press is overwritten

Behaviour:
- Interface: reset Rst_n, asynchronous, active-low; clock Clk. All state is updated on the Clk rising edge.
- Reset values:
  - uart_tx=1, tx_busy=0, tx_done=0, press_cnt=0, overrun=0
  - pending flag=0, pending data=0, state=IDLE, baud/bit counters=0
- Press event:
  - press_ev = key_flag & ~key_state, sampled at edge N.
  - Release events (key_flag & key_state) are ignored entirely.
  - On press_ev, press_cnt <= press_cnt+1 at edge N; wraps 255->0 with no flag.
  - The frame payload is the incremented value.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - uart_tx=1.
    - If press_ev: go to START; load shift reg with press_cnt+1. uart_tx is low from edge N (first cycle after the event).
    - Else if pending=1: go to START with pending data; clear pending.
  - START: uart_tx=0 for BAUD_DIV cycles, then DATA.
  - DATA:
    - 8 bits, LSB first, each held BAUD_DIV cycles.
    - Bit index 0..7; after bit 7 go to STOP.
  - STOP:
    - uart_tx=1 for BAUD_DIV cycles.
    - tx_done=1 in the final STOP cycle.
    - If pending=1, go directly to START with pending data (back-to-back, no idle gap). Else go to IDLE.
- Frame length: exactly 10*BAUD_DIV cycles.
- tx_busy: =1 in START/DATA/STOP, 0 in IDLE.
- Press while busy (state != IDLE, including the tx_done cycle):
  - Pending data <= new count; pending <= 1.
  - If pending was already 1, the old value is overwritten and overrun <= 1 (sticky until reset).
- Press in the tx_done cycle with pending=1: the old pending value is sent next and the new press is stored. This case is implemented as written, not treated as overrun. Net effect: the old value starts immediately, the new value stays pending.
- Baud counter:
  - Counts 0..BAUD_DIV-1 per bit; wraps to 0 at bit boundaries.
  - Held at 0 in IDLE.
- Reset mid-frame: line returns high immediately (asynchronously); the partial frame is abandoned; all counts clear.
- No combinational path from key inputs to uart_tx: uart_tx is driven from a register.

Test Plan:
- BAUD_DIV=4, reset only → uart_tx=1, tx_busy=0, press_cnt=0, overrun=0 for 100 cycles.
- BAUD_DIV=4, single press event → press_cnt=1; uart_tx waveform over the next 40 cycles is 0,1,0,0,0,0,0,0,0,1 per 4-cycle bit; tx_done pulses once at cycle 40; tx_busy is high for exactly 40 cycles.
- Release event only (key_flag=1, key_state=1) → no frame, press_cnt unchanged.
- Two presses 10 cycles apart → frame 0x01 then frame 0x02 back-to-back; the start bit of the second frame begins the cycle after tx_done; overrun=0.
- Three presses within the first frame → frames 0x01 then 0x03 are sent, 0x02 is lost; overrun=1 and stays 1; press_cnt=3.
- 256 presses spaced by ≥40 cycles → last frame carries 0x00, press_cnt=0 (wrap).
- Rst_n asserted at cycle 15 of a frame → uart_tx=1 and all outputs at reset values immediately; after release, the next press sends 0x01.

Source files
------------

// File: rtl/key_uart_sender_if.sv
//----------------------------------------------------------------------
// key_uart_sender_if : key event inputs and UART/status outputs
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface key_uart_sender_if;
  logic       key_flag;
  logic       key_state;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] press_cnt;
  logic       overrun;

  // master = key filter / host side, slave = the sender
  modport master (
    output key_flag, key_state,
    input  uart_tx, tx_busy, tx_done, press_cnt, overrun
  );

  modport slave (
    input  key_flag, key_state,
    output uart_tx, tx_busy, tx_done, press_cnt, overrun
  );
endinterface

`default_nettype wire

// File: rtl/key_uart_sender.sv
//----------------------------------------------------------------------
// key_uart_sender : counts key presses, sends each count as an 8N1 frame
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module key_uart_sender #(
  parameter int BAUD_DIV = 5208,
  parameter int CNT_W    = 16
) (
  input  wire logic          Clk,
  input  wire logic          Rst_n,
  key_uart_sender_if.slave   bus
);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       pend_data, pend_data_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             pend, pend_nxt;
  logic             ovr, ovr_nxt;
  logic             tx, tx_nxt;

  logic       press_ev;
  logic       baud_end;
  logic [7:0] cnt_inc;

  assign press_ev = bus.key_flag & ~bus.key_state;
  assign baud_end = (baud_cnt == BAUD_LAST);
  assign cnt_inc  = cnt + 8'd1;

  always_comb begin
    state_nxt     = state;
    baud_nxt      = baud_cnt;
    bit_nxt       = bit_idx;
    shift_nxt     = shift;
    pend_nxt      = pend;
    pend_data_nxt = pend_data;
    ovr_nxt       = ovr;
    cnt_nxt       = cnt;
    tx_nxt        = 1'b1;

    if (press_ev) begin
      cnt_nxt = cnt_inc;
    end

    // A press during the final stop cycle replaces a value that is leaving
    // the pending slot on the same edge, so nothing is lost there.
    if (press_ev && (state != IDLE)) begin
      pend_data_nxt = cnt_inc;
      pend_nxt      = 1'b1;
      if (pend && !((state == STOP) && baud_end)) begin
        ovr_nxt = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = 3'd0;
        if (press_ev) begin
          state_nxt = START;
          shift_nxt = cnt_inc;
        end else if (pend) begin
          state_nxt = START;
          shift_nxt = pend_data;
          pend_nxt  = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            bit_nxt   = 3'd0;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          bit_nxt  = 3'd0;
          if (pend) begin
            state_nxt = START;
            shift_nxt = pend_data;
            pend_nxt  = press_ev;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        bit_nxt   = 3'd0;
      end
    endcase

    // Line level is registered from the next state so uart_tx is glitch-free.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      pend      <= 1'b0;
      pend_data <= 8'd0;
      cnt       <= 8'd0;
      ovr       <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_idx   <= bit_nxt;
      shift     <= shift_nxt;
      pend      <= pend_nxt;
      pend_data <= pend_data_nxt;
      cnt       <= cnt_nxt;
      ovr       <= ovr_nxt;
      tx        <= tx_nxt;
    end
  end

  assign bus.uart_tx   = tx;
  assign bus.tx_busy   = (state != IDLE);
  assign bus.tx_done   = (state == STOP) && baud_end;
  assign bus.press_cnt = cnt;
  assign bus.overrun   = ovr;

endmodule

`default_nettype wire

// File: tb/tb_key_uart_sender.sv
//----------------------------------------------------------------------
// tb_key_uart_sender : directed self-checking bench, BAUD_DIV = 4
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_key_uart_sender;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  key_uart_sender_if bus ();

  key_uart_sender #(
    .BAUD_DIV (4),
    .CNT_W    (16)
  ) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    bus.key_flag  = 1'b0;
    bus.key_state = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Press sampled on the next rising edge; returns at the first frame cycle.
  task automatic pulse_press();
    bus.key_flag  = 1'b1;
    bus.key_state = 1'b0;
    @(negedge clk);
    bus.key_flag  = 1'b0;
    bus.key_state = 1'b1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Checks one whole frame (40 cycles) starting at the current negedge.
  // press_mask[k] injects a press sampled at the edge ending frame cycle k+1.
  task automatic expect_frame(input logic [7:0] exp, input logic [39:0] press_mask,
                              input string name);
    int   bad;
    int   b;
    logic exp_tx;
    logic exp_done;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      b        = k / 4;
      exp_tx   = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[b-1];
      exp_done = (k == 39);
      if (bus.uart_tx !== exp_tx || bus.tx_busy !== 1'b1 || bus.tx_done !== exp_done) begin
        if (bad == 0)
          $display("FAIL %s cycle=%0d tx,busy,done actual=%b%b%b required=%b1%b",
                   name, k + 1, bus.uart_tx, bus.tx_busy, bus.tx_done, exp_tx, exp_done);
        bad++;
      end
      bus.key_flag  = press_mask[k];
      bus.key_state = ~press_mask[k];
      @(negedge clk);
    end
    bus.key_flag  = 1'b0;
    bus.key_state = 1'b1;
    checks++;
    if (bad != 0) failures++;
  endtask

  task automatic check_idle(input string name, input int cycles, input logic [7:0] exp_cnt,
                            input logic exp_ovr);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      if (bus.uart_tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0 ||
          bus.press_cnt !== exp_cnt || bus.overrun !== exp_ovr) begin
        if (bad == 0)
          $display("FAIL %s cycle=%0d tx,busy,done,cnt,ovr actual=%b%b%b %h %b required=100 %h %b",
                   name, k, bus.uart_tx, bus.tx_busy, bus.tx_done, bus.press_cnt,
                   bus.overrun, exp_cnt, exp_ovr);
        bad++;
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  task automatic test_reset();
    do_reset();
    check_idle("reset_idle", 100, 8'd0, 1'b0);
  endtask

  task automatic test_single_press();
    do_reset();
    pulse_press();
    checks++;
    if (bus.press_cnt !== 8'd1) begin
      failures++;
      $display("FAIL single_cnt actual=%h required=01", bus.press_cnt);
    end
    expect_frame(8'h01, 40'd0, "single_frame");
    check_idle("single_after", 5, 8'd1, 1'b0);
  endtask

  task automatic test_release_only();
    do_reset();
    bus.key_flag  = 1'b1;
    bus.key_state = 1'b1;
    @(negedge clk);
    bus.key_flag  = 1'b0;
    check_idle("release_ignored", 50, 8'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [39:0] m;
    do_reset();
    pulse_press();
    m = 40'd0;
    m[9] = 1'b1;
    expect_frame(8'h01, m, "b2b_first");
    expect_frame(8'h02, 40'd0, "b2b_second");
    check_idle("b2b_after", 5, 8'd2, 1'b0);
  endtask

  task automatic test_overrun();
    logic [39:0] m;
    do_reset();
    pulse_press();
    m = 40'd0;
    m[5]  = 1'b1;
    m[20] = 1'b1;
    expect_frame(8'h01, m, "ovr_first");
    check_bit("ovr_set", bus.overrun, 1'b1);
    expect_frame(8'h03, 40'd0, "ovr_second");
    check_idle("ovr_sticky", 30, 8'd3, 1'b1);
  endtask

  task automatic test_done_cycle_press();
    logic [39:0] m;
    do_reset();
    pulse_press();
    m = 40'd0;
    m[10] = 1'b1;
    m[39] = 1'b1;
    expect_frame(8'h01, m, "donep_first");
    expect_frame(8'h02, 40'd0, "donep_second");
    expect_frame(8'h03, 40'd0, "donep_third");
    check_idle("donep_after", 5, 8'd3, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      v = 8'(i);
      pulse_press();
      expect_frame(v, 40'd0, "wrap_frame");
    end
    check_idle("wrap_after", 5, 8'd0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    do_reset();
    pulse_press();
    repeat (14) @(negedge clk);
    check_bit("mid_tx_low_before", bus.uart_tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_tx", bus.uart_tx, 1'b1);
    check_bit("mid_rst_busy", bus.tx_busy, 1'b0);
    checks++;
    if (bus.press_cnt !== 8'd0 || bus.overrun !== 1'b0 || bus.tx_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_state cnt,ovr,done actual=%h %b %b required=00 0 0",
               bus.press_cnt, bus.overrun, bus.tx_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse_press();
    expect_frame(8'h01, 40'd0, "mid_after_frame");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.key_flag  = 1'b0;
    bus.key_state = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_release_only();
    test_back_to_back();
    test_overrun();
    test_done_cycle_press();
    test_wrap();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
